// File: rtl/mmcm_drp_reconfig.sv
// Run-time output divider reconfiguration for an MMCME2_ADV over DRP.
// Holds the MMCM in reset, read-modify-writes both clock registers of the
// requested channel, releases reset and supervises re-lock with retries.
module mmcm_drp_reconfig #(
    parameter int unsigned NUM_OUT      = 1,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned DRP_TIMEOUT  = 255,
    parameter int unsigned RETRY_MAX    = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_chan,
    input  logic [6:0]  req_div,
    output logic        done,
    output logic        error,
    output logic        busy,
    output logic        locked_out,
    output logic        mmcm_rst,
    input  logic        mmcm_locked,
    output logic        drp_den,
    output logic        drp_dwe,
    output logic [6:0]  drp_daddr,
    output logic [15:0] drp_di,
    input  logic [15:0] drp_do,
    input  logic        drp_drdy
);

    localparam int unsigned CNT_MAX = (LOCK_TIMEOUT > DRP_TIMEOUT) ? LOCK_TIMEOUT : DRP_TIMEOUT;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned RW      = (RETRY_MAX < 2) ? 1 : $clog2(RETRY_MAX + 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_ASSERT_RST, ST_RD1, ST_WAIT_RD1, ST_WR1, ST_WAIT_WR1,
        ST_RD2, ST_WAIT_RD2, ST_WR2, ST_WAIT_WR2, ST_RELEASE, ST_WAIT_LOCK,
        ST_RETRY_RST
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       chan_q, chan_d;
    logic [6:0]       div_q, div_d;
    logic [15:0]      rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RW-1:0]    retry_q, retry_d;
    logic             quiet_q, quiet_d;
    logic             sync1_q, sync2_q;
    logic             mmcm_rst_q, mmcm_rst_d;
    logic             den_q, den_d, dwe_q, dwe_d;
    logic [6:0]       daddr_q, daddr_d;
    logic [15:0]      di_q, di_d;
    logic             done_q, done_d, error_q, error_d;
    logic             ready_q, ready_d, busy_q, busy_d;
    logic             locked_q, locked_d;

    logic             bad_req_c;
    logic [6:0]       reg1_addr_c;
    logic [5:0]       high_c, low_c;
    logic             edge_bit_c, no_count_c;

    // Register-1 DRP address of each clock output
    always_comb begin
        case (chan_q)
            3'd0:    reg1_addr_c = 7'h08;
            3'd1:    reg1_addr_c = 7'h0A;
            3'd2:    reg1_addr_c = 7'h0C;
            3'd3:    reg1_addr_c = 7'h0E;
            3'd4:    reg1_addr_c = 7'h10;
            3'd5:    reg1_addr_c = 7'h06;
            3'd6:    reg1_addr_c = 7'h12;
            default: reg1_addr_c = 7'h08;
        endcase
    end

    // Divisor to HIGH/LOW/EDGE/NO_COUNT; divide-by-1 bypasses the counter
    always_comb begin
        if (div_q == 7'd1) begin
            high_c     = 6'd1;
            low_c      = 6'd1;
            edge_bit_c = 1'b0;
            no_count_c = 1'b1;
        end else begin
            high_c     = div_q[6:1];
            low_c      = 6'(div_q - {1'b0, div_q[6:1]});
            edge_bit_c = div_q[0];
            no_count_c = 1'b0;
        end
    end

    assign bad_req_c = (req_div == 7'd0) || (req_div > 7'd126) || (32'(req_chan) >= NUM_OUT);

    // Next-state logic and registered-output decode
    always_comb begin
        state_d = state_q;
        chan_d  = chan_q;
        div_d   = div_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        quiet_d = quiet_q;
        done_d  = 1'b0;
        error_d = 1'b0;
        daddr_d = daddr_q;
        di_d    = di_q;

        case (state_q)
            ST_IDLE: begin
                if (req_valid && ready_q) begin
                    if (bad_req_c) begin
                        error_d = 1'b1;
                    end else begin
                        chan_d  = req_chan;
                        div_d   = req_div;
                        retry_d = '0;
                        state_d = ST_ASSERT_RST;
                    end
                end
            end
            ST_ASSERT_RST: state_d = ST_RD1;
            ST_RD1, ST_WR1, ST_RD2, ST_WR2: begin
                cnt_d   = '0;
                state_d = state_t'(state_q + 4'd1);
            end
            ST_WAIT_RD1, ST_WAIT_WR1, ST_WAIT_RD2, ST_WAIT_WR2: begin
                if (drp_drdy) begin
                    if (state_q == ST_WAIT_RD1 || state_q == ST_WAIT_RD2) begin
                        rd_d = drp_do;
                    end
                    state_d = state_t'(state_q + 4'd1);
                end else if (32'(cnt_q) + 32'd1 >= DRP_TIMEOUT) begin
                    // Abandon the update; the MMCM restarts on whatever it held
                    error_d = 1'b1;
                    quiet_d = 1'b1;
                    state_d = ST_RELEASE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                cnt_d   = '0;
                state_d = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (sync2_q) begin
                    done_d  = !quiet_q;
                    quiet_d = 1'b0;
                    retry_d = '0;
                    state_d = ST_IDLE;
                end else if (32'(cnt_q) + 32'd1 >= LOCK_TIMEOUT) begin
                    retry_d = retry_q + RW'(1);
                    if (32'(retry_d) < RETRY_MAX) begin
                        state_d = ST_RETRY_RST;
                    end else begin
                        error_d = 1'b1;
                        quiet_d = 1'b0;
                        retry_d = '0;
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RETRY_RST: state_d = ST_RELEASE;
            default:      state_d = ST_RELEASE;
        endcase

        mmcm_rst_d = (state_d inside {ST_ASSERT_RST, ST_RD1, ST_WAIT_RD1, ST_WR1, ST_WAIT_WR1,
                                      ST_RD2, ST_WAIT_RD2, ST_WR2, ST_WAIT_WR2, ST_RETRY_RST});
        den_d      = (state_d inside {ST_RD1, ST_WR1, ST_RD2, ST_WR2});
        dwe_d      = (state_d inside {ST_WR1, ST_WR2});
        if (state_d == ST_RD1 || state_d == ST_WR1) begin
            daddr_d = reg1_addr_c;
        end else if (state_d == ST_RD2 || state_d == ST_WR2) begin
            daddr_d = reg1_addr_c + 7'd1;
        end
        if (state_d == ST_WR1) begin
            di_d = (rd_d & 16'hF000) | {4'd0, high_c, low_c};
        end else if (state_d == ST_WR2) begin
            di_d = (rd_d & 16'hFF3F) | {8'd0, edge_bit_c, no_count_c, 6'd0};
        end
        ready_d  = (state_d == ST_IDLE);
        busy_d   = (state_d != ST_IDLE);
        locked_d = sync2_q && (state_d == ST_IDLE);
    end

    // State, datapath and output registers; reset starts a supervision pass
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RELEASE;
            chan_q     <= '0;
            div_q      <= '0;
            rd_q       <= '0;
            cnt_q      <= '0;
            retry_q    <= '0;
            quiet_q    <= 1'b1;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            mmcm_rst_q <= 1'b1;
            den_q      <= 1'b0;
            dwe_q      <= 1'b0;
            daddr_q    <= '0;
            di_q       <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            div_q      <= div_d;
            rd_q       <= rd_d;
            cnt_q      <= cnt_d;
            retry_q    <= retry_d;
            quiet_q    <= quiet_d;
            sync1_q    <= mmcm_locked;
            sync2_q    <= sync1_q;
            mmcm_rst_q <= mmcm_rst_d;
            den_q      <= den_d;
            dwe_q      <= dwe_d;
            daddr_q    <= daddr_d;
            di_q       <= di_d;
            done_q     <= done_d;
            error_q    <= error_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            locked_q   <= locked_d;
        end
    end

    assign req_ready  = ready_q;
    assign done       = done_q;
    assign error      = error_q;
    assign busy       = busy_q;
    assign locked_out = locked_q;
    assign mmcm_rst   = mmcm_rst_q;
    assign drp_den    = den_q;
    assign drp_dwe    = dwe_q;
    assign drp_daddr  = daddr_q;
    assign drp_di     = di_q;

endmodule

// File: tb/tb_mmcm_drp_reconfig.sv
// Directed bench: DRP register model and MMCM lock model around two instances
// (normal timeouts, and a short lock timeout with an MMCM that never locks).
module tb_mmcm_drp_reconfig;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, rst_b = 1'b1;
    logic        req_valid = 1'b0;
    logic [2:0]  req_chan = 3'd0;
    logic [6:0]  req_div = 7'd0;
    logic        lock_a = 1'b0, drdy_a = 1'b0;
    logic [15:0] do_a = 16'd0;
    logic        ready_a, done_a, error_a, busy_a, locked_out_a, mmcm_rst_a, den_a, dwe_a;
    logic [6:0]  daddr_a;
    logic [15:0] di_a;

    logic        b_valid = 1'b0, b_lock = 1'b0, b_drdy = 1'b0;
    logic [2:0]  b_chan = 3'd0;
    logic [6:0]  b_div = 7'd0;
    logic [15:0] b_do = 16'd0;
    logic        ready_b, done_b, error_b, busy_b, locked_out_b, mmcm_rst_b, den_b, dwe_b;
    logic [6:0]  daddr_b;
    logic [15:0] di_b;

    mmcm_drp_reconfig #(.NUM_OUT(3), .LOCK_TIMEOUT(65535), .DRP_TIMEOUT(20), .RETRY_MAX(3)) dut_a (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready_a),
        .req_chan(req_chan), .req_div(req_div), .done(done_a), .error(error_a),
        .busy(busy_a), .locked_out(locked_out_a), .mmcm_rst(mmcm_rst_a),
        .mmcm_locked(lock_a), .drp_den(den_a), .drp_dwe(dwe_a), .drp_daddr(daddr_a),
        .drp_di(di_a), .drp_do(do_a), .drp_drdy(drdy_a));

    mmcm_drp_reconfig #(.NUM_OUT(1), .LOCK_TIMEOUT(16), .DRP_TIMEOUT(255), .RETRY_MAX(2)) dut_b (
        .clk(clk), .rst(rst_b), .req_valid(b_valid), .req_ready(ready_b),
        .req_chan(b_chan), .req_div(b_div), .done(done_b), .error(error_b),
        .busy(busy_b), .locked_out(locked_out_b), .mmcm_rst(mmcm_rst_b),
        .mmcm_locked(b_lock), .drp_den(den_b), .drp_dwe(dwe_b), .drp_daddr(daddr_b),
        .drp_di(di_b), .drp_do(b_do), .drp_drdy(b_drdy));

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // DRP slave: drdy follows den by drp_lat cycles, reads come from mem
    logic [15:0] mem [128];
    logic [15:0] rd_val = 16'd0;
    logic [6:0]  wr_addr [$];
    logic [15:0] wr_data [$];
    int drp_lat = 1, pend = 0;
    always @(negedge clk) begin
        drdy_a <= 1'b0;
        if (pend != 0) begin
            pend <= pend - 1;
            if (pend == 1) begin
                drdy_a <= 1'b1;
                do_a   <= rd_val;
            end
        end
        if (den_a) begin
            if (dwe_a) begin
                wr_addr.push_back(daddr_a);
                wr_data.push_back(di_a);
            end else begin
                rd_val <= mem[daddr_a];
            end
            pend <= drp_lat;
        end
    end

    // MMCM lock model: loses lock in reset, locks lock_delay cycles after release
    int lock_delay = 40, lcnt = 0, lock_rise_cyc = 0;
    always @(negedge clk) begin
        if (mmcm_rst_a) begin
            lock_a <= 1'b0;
            lcnt   <= 0;
        end else if (lcnt < lock_delay) begin
            lcnt <= lcnt + 1;
        end else if (!lock_a) begin
            lock_a        <= 1'b1;
            lock_rise_cyc <= cyc;
        end
    end

    // Event counters sampled at the active edge
    int done_cnt = 0, err_cnt = 0, den_norst = 0;
    always @(posedge clk) begin
        if (!rst) begin
            if (done_a) done_cnt <= done_cnt + 1;
            if (error_a) err_cnt <= err_cnt + 1;
            if (den_a && !mmcm_rst_a) den_norst <= den_norst + 1;
        end
    end

    // Lock-failure instance: edges of mmcm_rst and error pulses
    logic prev_mrst_b = 1'b1;
    int falls_b = 0, rises_b = 0, fall0_b = 0, fall1_b = 0, rise1_b = 0;
    int err_b_cnt = 0, err_b_cyc = 0, done_b_cnt = 0;
    always @(posedge clk) begin
        prev_mrst_b <= mmcm_rst_b;
        if (!rst_b) begin
            if (prev_mrst_b && !mmcm_rst_b) begin
                if (falls_b == 0) fall0_b <= cyc; else fall1_b <= cyc;
                falls_b <= falls_b + 1;
            end
            if (!prev_mrst_b && mmcm_rst_b) begin
                rise1_b <= cyc;
                rises_b <= rises_b + 1;
            end
            if (error_b) begin
                err_b_cnt <= err_b_cnt + 1;
                err_b_cyc <= cyc;
            end
            if (done_b) done_b_cnt <= done_b_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [2:0] ch, input logic [6:0] dv);
        @(negedge clk);
        req_valid = 1'b1;
        req_chan  = ch;
        req_div   = dv;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int maxc);
        int n = 0;
        while (!(ready_a && locked_out_a) && n < maxc) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(ready_a && locked_out_a), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic chk_writes(input string tag, input int wb, input logic [6:0] a0,
                              input logic [15:0] d0, input logic [6:0] a1, input logic [15:0] d1);
        chk({tag, "_nwr"}, 32'(wr_addr.size() - wb), 32'd2);
        if (wr_addr.size() >= wb + 2) begin
            chk({tag, "_addr1"}, 32'(wr_addr[wb]), 32'(a0));
            chk({tag, "_data1"}, 32'(wr_data[wb]), 32'(d0));
            chk({tag, "_addr2"}, 32'(wr_addr[wb+1]), 32'(a1));
            chk({tag, "_data2"}, 32'(wr_data[wb+1]), 32'(d1));
        end
    endtask

    logic [2:0] bad_ch [3] = '{3'd0, 3'd0, 3'd3};
    logic [6:0] bad_dv [3] = '{7'd0, 7'd127, 7'd5};
    int n, wb, d0, e0;

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = 16'h0000;
        repeat (3) @(negedge clk);
        // Reset values
        chk("rst_mmcm_rst", 32'(mmcm_rst_a), 32'd1);
        chk("rst_busy", 32'(busy_a), 32'd1);
        chk("rst_ready", 32'(ready_a), 32'd0);
        chk("rst_locked", 32'(locked_out_a), 32'd0);
        chk("rst_den_dwe", 32'({den_a, dwe_a}), 32'd0);
        chk("rst_done_err", 32'({done_a, error_a}), 32'd0);
        chk("rst_addr_data", 32'({daddr_a, di_a}), 32'd0);

        // Post-reset supervision: release one cycle later, qualified lock, no done
        rst = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("post_rst_release", 32'(mmcm_rst_a), 32'd0);
        n = 0;
        while (!locked_out_a && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("post_rst_locked", 32'(locked_out_a), 32'd1);
        chk("lock_sync_latency", 32'((cyc - lock_rise_cyc) >= 2 && (cyc - lock_rise_cyc) <= 3), 32'd1);
        repeat (2) @(negedge clk);
        chk("post_rst_no_done", 32'(done_cnt), 32'd0);
        chk("post_rst_ready", 32'(ready_a), 32'd1);
        lock_delay = 3;

        // Never-locking MMCM with LOCK_TIMEOUT=16, RETRY_MAX=2
        n = 0;
        while (err_b_cnt == 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_error_once", 32'(err_b_cnt), 32'd1);
        chk("tmo_one_retry", 32'(rises_b), 32'd1);
        chk("tmo_window1", 32'(rise1_b - fall0_b), 32'd16);
        chk("tmo_retry_pulse", 32'(fall1_b - rise1_b), 32'd1);
        chk("tmo_window2", 32'(err_b_cyc - fall1_b), 32'd17);
        chk("tmo_locked_out", 32'(locked_out_b), 32'd0);
        chk("tmo_ready", 32'(ready_b), 32'd1);
        chk("tmo_no_done", 32'(done_b_cnt), 32'd0);

        // D=5 on channel 0
        mem[8'h08] = 16'hA5A5;
        mem[8'h09] = 16'h00C0;
        wb = wr_addr.size();
        d0 = done_cnt;
        e0 = err_cnt;
        do_req(3'd0, 7'd5);
        wait_idle("d5_relock", 200);
        chk_writes("d5", wb, 7'h08, 16'hA083, 7'h09, 16'h0080);
        chk("d5_done_once", 32'(done_cnt - d0), 32'd1);
        chk("d5_no_error", 32'(err_cnt - e0), 32'd0);

        // D=1 on channel 2: counter bypass
        wb = wr_addr.size();
        d0 = done_cnt;
        do_req(3'd2, 7'd1);
        wait_idle("d1_relock", 200);
        chk_writes("d1", wb, 7'h0C, 16'h0041, 7'h0D, 16'h0040);
        chk("d1_done_once", 32'(done_cnt - d0), 32'd1);

        // D=126 on channel 1: largest divisor, preserved bits kept
        mem[8'h0A] = 16'h1234;
        mem[8'h0B] = 16'h5A5A;
        wb = wr_addr.size();
        do_req(3'd1, 7'd126);
        wait_idle("d126_relock", 200);
        chk_writes("d126", wb, 7'h0A, 16'h1FFF, 7'h0B, 16'h5A1A);

        // Rejected requests: error next cycle, no DRP traffic, never busy
        for (int i = 0; i < 3; i++) begin
            wb = wr_addr.size();
            do_req(bad_ch[i], bad_dv[i]);
            chk("bad_err_pulse", 32'(error_a), 32'd1);
            chk("bad_not_busy", 32'(busy_a), 32'd0);
            @(negedge clk);
            chk("bad_err_single", 32'(error_a), 32'd0);
            chk("bad_ready", 32'({ready_a, busy_a, den_a}), 32'd4);
            chk("bad_no_drp", 32'(wr_addr.size() - wb), 32'd0);
        end

        // DRP slave never answers: error, no writes, relock without done
        drp_lat = 60;
        wb = wr_addr.size();
        d0 = done_cnt;
        e0 = err_cnt;
        do_req(3'd0, 7'd3);
        n = 0;
        while (err_cnt == e0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drp_tmo_error", 32'(err_cnt - e0), 32'd1);
        wait_idle("drp_tmo_relock", 200);
        chk("drp_tmo_no_write", 32'(wr_addr.size() - wb), 32'd0);
        chk("drp_tmo_no_done", 32'(done_cnt - d0), 32'd0);
        repeat (70) @(negedge clk);

        // Reset during WAIT_WR1, drdy arrives afterwards
        drp_lat = 3;
        d0 = done_cnt;
        e0 = err_cnt;
        do_req(3'd0, 7'd3);
        n = 0;
        while (!(den_a && dwe_a) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("mid_wr1_seen", 32'(den_a && dwe_a), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_mmcm_rst", 32'(mmcm_rst_a), 32'd1);
        chk("mid_drp_idle", 32'({den_a, dwe_a, daddr_a, di_a}), 32'd0);
        chk("mid_flags", 32'({busy_a, ready_a, locked_out_a, done_a, error_a}), 32'h10);
        rst = 1'b0;
        wait_idle("mid_relock", 200);
        chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mid_no_error", 32'(err_cnt - e0), 32'd0);
        chk("den_only_in_reset", 32'(den_norst), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
